// File: rtl/vga_scan_driver_if.sv
// Pixel-side and pin-side signals of the raster scan driver.
// master = scan driver, slave = sprite logic / VGA connector side.
interface vga_scan_driver_if;
  logic [23:0] color_in;
  logic [9:0]  x_pixel;
  logic [9:0]  y_pixel;
  logic        active;
  logic        pixel_tick;
  logic        frame_start;
  logic [7:0]  vga_r;
  logic [7:0]  vga_g;
  logic [7:0]  vga_b;
  logic        vga_hs;
  logic        vga_vs;
  logic        vga_blank_n;

  modport master (
    input  color_in,
    output x_pixel, y_pixel, active, pixel_tick, frame_start,
    output vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n
  );

  modport slave (
    output color_in,
    input  x_pixel, y_pixel, active, pixel_tick, frame_start,
    input  vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n
  );
endinterface

// File: rtl/vga_scan_driver.sv
// VGA raster scan: pixel divider, h/v counters, one-pixel-latency DAC/sync stage.
// Define VGA_TEST_PATTERN_EN to replace color_in with eight 80-px colour bars.
module vga_scan_driver #(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic              clk,
  input  logic              rst,
  vga_scan_driver_if.master bus
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             pixel_tick_q, pixel_tick_d;
  logic [9:0]       h_cnt_q, h_cnt_d;
  logic [9:0]       v_cnt_q, v_cnt_d;
  logic             frame_start_q, frame_start_d;
  logic [23:0]      rgb_q, rgb_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic             blank_n_q, blank_n_d;

  logic        active;
  logic        in_hsync;
  logic        in_vsync;
  logic        line_end;
  logic        frame_end;
  logic [23:0] pix_color;

  assign active    = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
  assign in_hsync  = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
  assign in_vsync  = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);
  assign line_end  = (h_cnt_q == H_LAST);
  assign frame_end = line_end && (v_cnt_q == V_LAST);

`ifdef VGA_TEST_PATTERN_EN
  always_comb begin
    pix_color = 24'h000000;
    if      (h_cnt_q < 10'd80)  pix_color = 24'hFFFFFF;
    else if (h_cnt_q < 10'd160) pix_color = 24'hFFFF00;
    else if (h_cnt_q < 10'd240) pix_color = 24'h00FFFF;
    else if (h_cnt_q < 10'd320) pix_color = 24'h00FF00;
    else if (h_cnt_q < 10'd400) pix_color = 24'hFF00FF;
    else if (h_cnt_q < 10'd480) pix_color = 24'hFF0000;
    else if (h_cnt_q < 10'd560) pix_color = 24'h0000FF;
  end
`else
  assign pix_color = bus.color_in;
`endif

  always_comb begin
    div_cnt_d     = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
    pixel_tick_d  = (div_cnt_q == DIV_LAST);
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    rgb_d         = rgb_q;
    hs_d          = hs_q;
    vs_d          = vs_q;
    blank_n_d     = blank_n_q;
    frame_start_d = pixel_tick_q && frame_end;
    // Output stage samples the pre-increment coordinate, giving one pixel of latency.
    if (pixel_tick_q) begin
      if (line_end) begin
        h_cnt_d = 10'd0;
        v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
      rgb_d     = active ? pix_color : 24'h000000;
      hs_d      = !in_hsync;
      vs_d      = !in_vsync;
      blank_n_d = active;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_q     <= '0;
      pixel_tick_q  <= 1'b0;
      h_cnt_q       <= 10'd0;
      v_cnt_q       <= 10'd0;
      frame_start_q <= 1'b0;
      rgb_q         <= 24'h000000;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_n_q     <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      pixel_tick_q  <= pixel_tick_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      frame_start_q <= frame_start_d;
      rgb_q         <= rgb_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_n_q     <= blank_n_d;
    end
  end

  assign bus.x_pixel     = h_cnt_q;
  assign bus.y_pixel     = v_cnt_q;
  assign bus.active      = active;
  assign bus.pixel_tick  = pixel_tick_q;
  assign bus.frame_start = frame_start_q;
  assign bus.vga_r       = rgb_q[23:16];
  assign bus.vga_g       = rgb_q[15:8];
  assign bus.vga_b       = rgb_q[7:0];
  assign bus.vga_hs      = hs_q;
  assign bus.vga_vs      = vs_q;
  assign bus.vga_blank_n = blank_n_q;

endmodule

// File: tb/tb_vga_scan_driver.sv
// Self-checking bench for vga_scan_driver with a shrunken raster (32x19) so whole
// frames fit in a short run; expected outputs come from pixel-count arithmetic.
module tb_vga_scan_driver;
  localparam int CLK_DIV = 2;
  localparam int HV = 20, HF = 3, HS = 5, HB = 4;
  localparam int VV = 12, VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;   // 32
  localparam int VT = VV + VF + VS + VB;   // 19
  localparam int FRAME = HT * VT;          // 608 pixels

  logic clk = 1'b0;
  logic rst = 1'b0;
  vga_scan_driver_if bus();

  vga_scan_driver #(
    .CLK_DIV(CLK_DIV), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int t        = 0;      // clock edges since reset release
  bit started  = 1'b0;
  bit color_mode = 1'b0; // 0: random table, 1: constant 00FF19
  logic [23:0] tab [HT];

  int first_tick_t = -1, first_hs_fall_t = -1, hs_len = -1, vs_len = -1;
  int first_fs_t = -1, fs_period = -1, last_fs_t = -1, hs_fall_t = -1, vs_fall_t = -1;
  logic [23:0] rgb_at_t3 = 24'hxxxxxx;
  bit prev_hs = 1'b1, prev_vs = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0d)", name, act, exp, t);
    end
  endtask

  function automatic logic [23:0] color_of(input int x, input int y);
    logic [23:0] yy;
    yy = 24'(y);
    if (color_mode) return 24'h00FF19;
    return tab[x % HT] ^ (yy * 24'h010203);
  endfunction

  function automatic logic [23:0] expected_color(input int x, input int y);
`ifdef VGA_TEST_PATTERN_EN
    logic [23:0] bars [8];
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    return bars[x / 80];
`else
    return color_of(x, y);
`endif
  endfunction

  // Edge counter since release.
  initial forever begin
    @(posedge clk);
    t = rst ? t + 1 : 0;
  end

  // Sprite-side colour source; garbage on clocks where no sample may be taken.
  initial forever begin
    @(negedge clk);
    bus.color_in = bus.pixel_tick ? color_of(int'(bus.x_pixel), int'(bus.y_pixel))
                                  : 24'($urandom);
  end

  // Per-cycle compare against the pixel-count model.
  initial forever begin
    int n, p, xo, yo;
    bit act_o, e_tick, e_fs;
    logic [23:0] e_rgb;
    @(negedge clk);
    if (!started) continue;
    if (!rst) begin
      check("rst_x", bus.x_pixel, 0);
      check("rst_y", bus.y_pixel, 0);
      check("rst_tick", bus.pixel_tick, 0);
      check("rst_fs", bus.frame_start, 0);
      check("rst_rgb", {bus.vga_r, bus.vga_g, bus.vga_b}, 0);
      check("rst_hs", bus.vga_hs, 1);
      check("rst_vs", bus.vga_vs, 1);
      check("rst_blank", bus.vga_blank_n, 0);
      prev_hs = 1'b1; prev_vs = 1'b1;
      continue;
    end
    n      = (t >= 1) ? (t - 1) / CLK_DIV : 0;
    e_tick = (t >= 1) && (t % CLK_DIV == 0);
    e_fs   = (n > 0) && (n % FRAME == 0) && ((t - 1) % CLK_DIV == 0);
    check("x_pixel", bus.x_pixel, n % HT);
    check("y_pixel", bus.y_pixel, (n / HT) % VT);
    check("active", bus.active, ((n % HT) < HV) && (((n / HT) % VT) < VV));
    check("pixel_tick", bus.pixel_tick, e_tick);
    check("frame_start", bus.frame_start, e_fs);
    if (n == 0) begin
      check("rgb0", {bus.vga_r, bus.vga_g, bus.vga_b}, 0);
      check("hs0", bus.vga_hs, 1);
      check("vs0", bus.vga_vs, 1);
      check("blank0", bus.vga_blank_n, 0);
    end else begin
      p = n - 1;
      xo = p % HT;
      yo = (p / HT) % VT;
      act_o = (xo < HV) && (yo < VV);
      e_rgb = act_o ? expected_color(xo, yo) : 24'h000000;
      check("rgb", {bus.vga_r, bus.vga_g, bus.vga_b}, e_rgb);
      check("vga_hs", bus.vga_hs, !(xo >= HV + HF && xo < HV + HF + HS));
      check("vga_vs", bus.vga_vs, !(yo >= VV + VF && yo < VV + VF + VS));
      check("blank_n", bus.vga_blank_n, act_o);
    end
    // Measurements pinned by literal expectations in the main sequence.
    if (t == 3) rgb_at_t3 = {bus.vga_r, bus.vga_g, bus.vga_b};
    if (bus.pixel_tick && first_tick_t < 0) first_tick_t = t;
    if (prev_hs && !bus.vga_hs) begin
      hs_fall_t = t;
      if (first_hs_fall_t < 0) first_hs_fall_t = t;
    end
    if (!prev_hs && bus.vga_hs && hs_len < 0) hs_len = t - hs_fall_t;
    if (prev_vs && !bus.vga_vs) vs_fall_t = t;
    if (!prev_vs && bus.vga_vs && vs_len < 0) vs_len = t - vs_fall_t;
    if (bus.frame_start) begin
      if (first_fs_t < 0) first_fs_t = t;
      else if (fs_period < 0) fs_period = t - last_fs_t;
      last_fs_t = t;
    end
    prev_hs = bus.vga_hs;
    prev_vs = bus.vga_vs;
  end

  initial begin
    bit found;
    for (int i = 0; i < HT; i++) tab[i] = 24'($urandom);
    bus.color_in = 24'h0;
    repeat (3) @(posedge clk);
    started = 1'b1;
    @(negedge clk);
    #2 rst = 1'b1;

    // Phase 1: random colours over more than two frames.
    repeat (2800) @(posedge clk);
    check("first_tick_t", first_tick_t, 2);
    check("first_hs_fall_t", first_hs_fall_t, 49);
    check("hs_low_clks", hs_len, 10);
    check("vs_low_clks", vs_len, 128);
    check("first_frame_start_t", first_fs_t, 1217);
    check("frame_period", fs_period, 1216);

    // Mid-frame asynchronous reset at (10,7).
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge clk);
      if (bus.x_pixel == 10'd10 && bus.y_pixel == 10'd7) found = 1'b1;
    end
    check("reach_10_7", found, 1);
    #2 rst = 1'b0;
    #1;
    check("async_x", bus.x_pixel, 0);
    check("async_y", bus.y_pixel, 0);
    check("async_hs", bus.vga_hs, 1);
    check("async_blank", bus.vga_blank_n, 0);
    check("async_rgb", {bus.vga_r, bus.vga_g, bus.vga_b}, 0);
    color_mode = 1'b1;
    first_fs_t = -1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;

    // Phase 2: constant colour, checks blanking zeroes and clean restart.
    repeat (1300) @(posedge clk);
`ifndef VGA_TEST_PATTERN_EN
    check("const_rgb_t3", rgb_at_t3, 24'h00FF19);
`endif
    check("restart_fs_t", first_fs_t, 1217);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
